// File: rtl/bnn_pkg.sv
// bnn_pkg: shared BNN defaults and the window pixel index function
package bnn_pkg;
  localparam int BNN_DATA_WIDTH = 4;
  localparam int BNN_K = 4;
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction
endpackage

// File: rtl/bnn_line_buffer.sv
// bnn_line_buffer: one image row store, read-before-write at a single address
// ports: clk; we_i write enable; addr_i column; wdata_i new pixel; rdata_o old pixel at addr_i
module bnn_line_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  assign rdata_o = mem_q[addr_i];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/bnn_window_gen.sv
// bnn_window_gen: raster pixel stream to KxK sliding windows for the BNN convolution
// ports: clk, rst (sync, active high); in_valid/in_ready/in_data raster pixel input;
//        out_valid/out_ready/out_window/out_last packed window output, out_last on final window of a frame
module bnn_window_gen
  import bnn_pkg::*;
#(
  parameter int DATA_WIDTH = BNN_DATA_WIDTH,
  parameter int K = BNN_K,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [K*K*DATA_WIDTH-1:0] out_window,
  output logic                      out_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic accept, qual, col_wrap, row_wrap;
  logic [DATA_WIDTH-1:0] lb_rd [K-1];
  logic [DATA_WIDTH-1:0] new_col [K];
  logic [DATA_WIDTH-1:0] win_q [K][K];
  logic [DATA_WIDTH-1:0] win_d [K][K];
  assign in_ready = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
  assign col_wrap = col_q == CW'(IMG_W - 1);
  assign row_wrap = row_q == RW'(IMG_H - 1);
  assign qual = row_q >= RW'(K - 1) && col_q >= CW'(K - 1);
  assign out_valid = out_valid_q;
  assign out_last = out_last_q;
  // each buffer passes its old entry up to the next one, so buffer i holds row (current - 1 - i)
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    logic [DATA_WIDTH-1:0] wd;
    if (i == 0) begin : g_head
      assign wd = in_data;
    end else begin : g_chain
      assign wd = lb_rd[i-1];
    end
    bnn_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_WIDTH)) u_lb (
      .clk    (clk),
      .we_i   (accept),
      .addr_i (col_q),
      .wdata_i(wd),
      .rdata_o(lb_rd[i])
    );
  end
  for (genvar r = 0; r < K; r++) begin : g_col
    if (r == K - 1) begin : g_bot
      assign new_col[r] = in_data;
    end else begin : g_up
      assign new_col[r] = lb_rd[K-2-r];
    end
  end
  for (genvar r = 0; r < K; r++) begin : g_pr
    for (genvar c = 0; c < K; c++) begin : g_pc
      assign out_window[win_idx(r, c, K)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
    end
  end
  always_comb begin
    col_d = accept ? (col_wrap ? '0 : col_q + CW'(1)) : col_q;
    row_d = (accept && col_wrap) ? (row_wrap ? '0 : row_q + RW'(1)) : row_q;
    out_valid_d = accept ? qual : out_valid_q && !out_ready;
    out_last_d = accept ? qual && row_wrap && col_wrap : out_last_q && !out_ready;
    win_d = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_d[r][c] = accept ? win_q[r][c+1] : win_q[r][c];
      win_d[r][K-1] = accept ? new_col[r] : win_q[r][K-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      win_q <= win_d;
    end
  end
endmodule

// File: tb/tb_bnn_window_gen.sv
// tb_bnn_window_gen: randomized self-checking bench against an image-array window model
module tb_bnn_window_gen;
  localparam int DW = 4, K = 4, W = 16, H = 16;
  localparam int FRAME = W * H, WPF = (H - K + 1) * (W - K + 1), NP = 10 * FRAME;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic [K*K*DW-1:0] out_window;
  logic [DW-1:0] pixmem [NP];
  logic [K*K*DW-1:0] got_w[$], exp_w[$];
  logic got_l[$];
  int checks = 0, errors = 0;

  bnn_window_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [K*K*DW-1:0] exp_win(input int fb, input int r, input int c);
    logic [K*K*DW-1:0] w = '0;
    for (int rr = 0; rr < K; rr++)
      for (int cc = 0; cc < K; cc++)
        w[(rr*K+cc)*DW +: DW] = pixmem[fb + (r - K + 1 + rr) * W + (c - K + 1 + cc)];
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic first_window(input int base, output int acc);
    int cyc = 0;
    acc = 0; in_valid = 1'b1; out_ready = 1'b1;
    while (!out_valid && cyc < 400) begin
      in_data = pixmem[base + acc];
      #1;
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input string name, input int base, input int npix, input int pv, input int pr);
    int p = 0, budget = 0, fp, r, c, nexp;
    got_w.delete(); got_l.delete(); exp_w.delete();
    while ((p < npix || out_valid) && budget < 20000) begin
      in_valid = (p < npix) && ($urandom_range(99) < pv);
      in_data = pixmem[base + (p < npix ? p : 0)];
      out_ready = $urandom_range(99) < pr;
      #1;
      if (out_valid && out_ready) begin got_w.push_back(out_window); got_l.push_back(out_last); end
      if (in_valid && in_ready) begin
        fp = p % FRAME; r = fp / W; c = fp % W;
        if (r >= K - 1 && c >= K - 1) exp_w.push_back(exp_win(base + p - fp, r, c));
        p++;
      end
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    checks++;
    if (budget >= 20000) begin errors++; $display("FAIL %s timeout accepted %0d of %0d", name, p, npix); end
    nexp = (npix / FRAME) * WPF;
    checks++;
    if (got_w.size() != nexp) begin errors++; $display("FAIL %s window_count got %0d exp %0d", name, got_w.size(), nexp); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      checks++;
      if (got_w[i] !== exp_w[i]) begin errors++; $display("FAIL %s window[%0d] got %h exp %h", name, i, got_w[i], exp_w[i]); end
      checks++;
      if (got_l[i] !== (i % WPF == WPF - 1)) begin errors++; $display("FAIL %s last[%0d] got %b exp %b", name, i, got_l[i], i % WPF == WPF - 1); end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset out_last got %b exp 0", out_last); end
    checks++; if (out_window !== '0) begin errors++; $display("FAIL reset out_window got %h exp 0", out_window); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_first_window();
    int acc;
    do_reset();
    first_window(0, acc);
    checks++; if (acc != 52) begin errors++; $display("FAIL first_latency accepts got %0d exp 52", acc); end
    for (int j = 0; j < K * K; j++) begin
      checks++;
      if (out_window[j*DW +: DW] !== DW'((j / K + j % K) & 15)) begin
        errors++; $display("FAIL first_slice[%0d] got %0d exp %0d", j, out_window[j*DW +: DW], (j / K + j % K) & 15);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    do_reset();
    run("full_frame", FRAME, FRAME, 100, 100);
  endtask

  task automatic test_back_to_back();
    int lasts = 0;
    do_reset();
    run("back_to_back", 2 * FRAME, 2 * FRAME, 100, 100);
    foreach (got_l[i]) if (got_l[i]) lasts++;
    checks++; if (lasts != 2) begin errors++; $display("FAIL b2b last_pulses got %0d exp 2", lasts); end
  endtask

  task automatic test_random_gaps();
    do_reset();
    run("random_gaps", 4 * FRAME, 2 * FRAME, 70, 60);
  endtask

  task automatic test_stall();
    int acc;
    logic [K*K*DW-1:0] w0;
    logic l0;
    do_reset();
    first_window(6 * FRAME, acc);
    checks++; if (out_window !== exp_win(6 * FRAME, 3, 3)) begin errors++; $display("FAIL stall_pre window got %h exp %h", out_window, exp_win(6 * FRAME, 3, 3)); end
    w0 = exp_win(6 * FRAME, 3, 3); l0 = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = pixmem[6 * FRAME + 52];
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall in_ready[%0d] got %b exp 0", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall out_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_window !== w0) begin errors++; $display("FAIL stall window[%0d] got %h exp %h", i, out_window, w0); end
      checks++; if (out_last !== l0) begin errors++; $display("FAIL stall last[%0d] got %b exp %b", i, out_last, l0); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_release out_valid got %b exp 1", out_valid); end
    checks++; if (out_window !== exp_win(6 * FRAME, 3, 4)) begin errors++; $display("FAIL stall_release window got %h exp %h", out_window, exp_win(6 * FRAME, 3, 4)); end
  endtask

  task automatic test_reset_mid();
    int p = 0, cyc = 0, acc;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    while (p < 7 * W + 9 && cyc < 400) begin
      in_data = pixmem[7 * FRAME + p];
      #1;
      if (in_valid && in_ready) p++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid pre out_valid got %b exp 1", out_valid); end
    in_data = pixmem[7 * FRAME + p]; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got %b exp 0", out_valid); end
    checks++; if (out_window !== '0) begin errors++; $display("FAIL rst_mid out_window got %h exp 0", out_window); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_mid out_last got %b exp 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready got %b exp 1", in_ready); end
    first_window(8 * FRAME, acc);
    checks++; if (acc != 52) begin errors++; $display("FAIL rst_mid latency accepts got %0d exp 52", acc); end
    checks++; if (out_window !== exp_win(8 * FRAME, 3, 3)) begin errors++; $display("FAIL rst_mid window got %h exp %h", out_window, exp_win(8 * FRAME, 3, 3)); end
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) pixmem[i] = DW'($urandom);
    for (int i = 0; i < FRAME; i++) pixmem[i] = DW'((i / W + i % W) & 15);
    test_reset();
    test_first_window();
    test_full_frame();
    test_back_to_back();
    test_random_gaps();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
